// File: rtl/register_scoreboard.sv
// register_scoreboard: tracks in-flight register writes and stalls decode on pending sources or saturated destinations
// ports: clk/reset (sync, active-high); reg1/reg2 address+use, issue_valid/issue_reg_write/issue_rd from decode;
//        wb_reg_write/wb_address from writeback; stall (comb), busy_mask, in_flight, underflow_err (registered)
module register_scoreboard #(
  parameter int MAX_PENDING = 3,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          reg1_address,
  input  logic [4:0]          reg2_address,
  input  logic                reg1_use,
  input  logic                reg2_use,
  input  logic                issue_valid,
  input  logic                issue_reg_write,
  input  logic [4:0]          issue_rd,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_address,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [7:0]          in_flight,
  output logic                underflow_err
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  logic [CNT_W-1:0] pending_q [NUM_REGS];
  logic [CNT_W-1:0] pending_d [NUM_REGS];
  logic [7:0] in_flight_q, in_flight_d;
  logic underflow_q, underflow_d;
  logic dec, inc, hz1, hz2, sat;
  logic [CNT_W-1:0] eff1, eff2, eff_rd;
  assign dec = wb_reg_write && wb_address != '0 && pending_q[wb_address] != '0;
  // the register file writes on negedge, so a retiring value is already visible to this cycle's read
  assign eff1 = pending_q[reg1_address] - CNT_W'(dec && wb_address == reg1_address);
  assign eff2 = pending_q[reg2_address] - CNT_W'(dec && wb_address == reg2_address);
  assign eff_rd = pending_q[issue_rd] - CNT_W'(dec && wb_address == issue_rd);
  assign hz1 = reg1_use && reg1_address != '0 && eff1 != '0;
  assign hz2 = reg2_use && reg2_address != '0 && eff2 != '0;
  assign sat = issue_reg_write && issue_rd != '0 && eff_rd == CNT_W'(MAX_PENDING);
  assign stall = issue_valid && (hz1 || hz2 || sat);
  assign inc = issue_valid && !stall && issue_reg_write && issue_rd != '0;
  assign in_flight_d = in_flight_q + 8'(inc) - 8'(dec);
  assign underflow_d = underflow_q | (wb_reg_write && wb_address != '0 && pending_q[wb_address] == '0);
  assign in_flight = in_flight_q;
  assign underflow_err = underflow_q;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_d[r] = r == 0 ? '0 : pending_q[r] + CNT_W'(inc && issue_rd == 5'(r)) - CNT_W'(dec && wb_address == 5'(r));
      busy_mask[r] = pending_q[r] != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) pending_q[r] <= '0;
      in_flight_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      in_flight_q <= in_flight_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed self-checking bench for register_scoreboard
module tb_register_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] reg1_address, reg2_address, issue_rd, wb_address;
  logic reg1_use, reg2_use, issue_valid, issue_reg_write, wb_reg_write;
  logic stall, underflow_err;
  logic [31:0] busy_mask;
  logic [7:0] in_flight;
  int checks = 0;
  int errors = 0;
  register_scoreboard dut (
    .clk(clk), .reset(reset),
    .reg1_address(reg1_address), .reg2_address(reg2_address),
    .reg1_use(reg1_use), .reg2_use(reg2_use),
    .issue_valid(issue_valid), .issue_reg_write(issue_reg_write), .issue_rd(issue_rd),
    .wb_reg_write(wb_reg_write), .wb_address(wb_address),
    .stall(stall), .busy_mask(busy_mask), .in_flight(in_flight), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset = 0; reg1_address = 0; reg2_address = 0; reg1_use = 0; reg2_use = 0;
    issue_valid = 0; issue_reg_write = 0; issue_rd = 0; wb_reg_write = 0; wb_address = 0;
  endtask
  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_reg_write = 1; issue_rd = rd;
  endtask
  task automatic wb(input logic [4:0] a);
    wb_reg_write = 1; wb_address = a;
  endtask
  task automatic test_reset();
    idle(); reset = 1; step(); step(); reset = 0; #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_mask, 32'h0); end
    checks++; if (in_flight !== 8'd0) begin errors++; $display("FAIL reset_in_flight got %0d exp 0", in_flight); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow_err); end
  endtask
  task automatic test_bypass();
    idle(); issue(5); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_issue_stall got %b exp 0", stall); end
    step(); idle(); #1;
    checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL bypass_busy5 got %h exp %h", busy_mask, 32'h20); end
    checks++; if (in_flight !== 8'd1) begin errors++; $display("FAIL bypass_in_flight1 got %0d exp 1", in_flight); end
    issue_valid = 1; reg1_use = 1; reg1_address = 5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bypass_hz1 got %b exp 1", stall); end
    reg1_use = 0; reg2_use = 1; reg2_address = 5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bypass_hz2 got %b exp 1", stall); end
    reg1_use = 1; reg2_use = 0; wb(5); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_wb_stall got %b exp 0", stall); end
    step(); idle(); #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL bypass_busy_clear got %h exp 0", busy_mask); end
    checks++; if (in_flight !== 8'd0) begin errors++; $display("FAIL bypass_in_flight0 got %0d exp 0", in_flight); end
  endtask
  task automatic test_x0();
    idle(); issue(0); step(); idle();
    issue_valid = 1; reg1_use = 1; reg2_use = 1; wb(0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", stall); end
    step(); idle(); #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy got %h exp 0", busy_mask); end
    checks++; if (in_flight !== 8'd0) begin errors++; $display("FAIL x0_in_flight got %0d exp 0", in_flight); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL x0_wb_underflow got %b exp 0", underflow_err); end
  endtask
  task automatic test_saturation();
    idle();
    for (int i = 0; i < 3; i++) begin
      issue(7); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_issue%0d_stall got %b exp 0", i, stall); end
      step();
    end
    idle(); #1;
    checks++; if (in_flight !== 8'd3) begin errors++; $display("FAIL sat_in_flight3 got %0d exp 3", in_flight); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sat_busy7 got %h exp %h", busy_mask, 32'h80); end
    issue(7); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_fourth_stall got %b exp 1", stall); end
    issue_valid = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_novalid_stall got %b exp 0", stall); end
    issue_valid = 1; wb(7); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_wb_accept got %b exp 0", stall); end
    step(); idle(); #1;
    checks++; if (in_flight !== 8'd3) begin errors++; $display("FAIL sat_in_flight_hold got %0d exp 3", in_flight); end
    issue(7); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_still_full got %b exp 1", stall); end
    idle();
    for (int i = 0; i < 3; i++) begin wb(7); step(); end
    idle(); #1;
    checks++; if (in_flight !== 8'd0 || busy_mask !== 32'h0) begin errors++; $display("FAIL sat_drain got %0d/%h exp 0/0", in_flight, busy_mask); end
  endtask
  task automatic test_back_to_back();
    idle(); issue(9); step(); idle();
    issue(9); wb(9); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_same_stall got %b exp 0", stall); end
    step(); idle(); #1;
    checks++; if (in_flight !== 8'd1) begin errors++; $display("FAIL b2b_same_in_flight got %0d exp 1", in_flight); end
    checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL b2b_same_busy got %h exp %h", busy_mask, 32'h200); end
    issue(10); wb(9); step(); idle(); #1;
    checks++; if (in_flight !== 8'd1) begin errors++; $display("FAIL b2b_diff_in_flight got %0d exp 1", in_flight); end
    checks++; if (busy_mask !== 32'h400) begin errors++; $display("FAIL b2b_diff_busy got %h exp %h", busy_mask, 32'h400); end
    wb(10); step(); idle(); #1;
    checks++; if (in_flight !== 8'd0 || underflow_err !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0d/%b exp 0/0", in_flight, underflow_err); end
  endtask
  task automatic test_underflow();
    idle(); wb(12); step(); idle(); #1;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", underflow_err); end
    checks++; if (busy_mask !== 32'h0 || in_flight !== 8'd0) begin errors++; $display("FAIL uf_counts got %h/%0d exp 0/0", busy_mask, in_flight); end
    step(); #1;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
    issue(3); step(); idle(); reset = 1; issue(4); step(); idle(); #1;
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_reset got %b exp 0", underflow_err); end
    checks++; if (busy_mask !== 32'h0 || in_flight !== 8'd0) begin errors++; $display("FAIL uf_reset_counts got %h/%0d exp 0/0", busy_mask, in_flight); end
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_saturation();
    test_back_to_back();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
